iccm_ram_arbiter: RTL
=====================

ICCM_RAM_ARBITER -- requirements
Module: iccm_ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, the DFFRAM word-address width.
REQ-002 SHALL have parameter MAX_WAIT, default 4, the number of consecutive stalled core cycles before the core is forced priority; legal range 1..15.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have core request ports, all inputs: core_req_i (1), core_we_i (1), core_addr_i (AW), core_wdata_i (32), core_wmask_i (32, bit mask).
REQ-006 SHALL have core response ports, all outputs: core_gnt_o (1, request accepted this cycle), core_rdata_o (32), core_rvalid_o (1).
REQ-007 SHALL have program-loader ports: prog_req_i (input, 1, write-only), prog_addr_i (input, AW), prog_wdata_i (input, 32) and prog_gnt_o (output, 1).
REQ-008 SHALL have RAM ports: ram_en_o (output, 1), ram_we_o (output, 4, byte enables), ram_a_o (output, AW), ram_di_o (output, 32) and ram_do_i (input, 32).
REQ-009 SHALL have port conflict_cnt_o, output, 16, the performance counter.

Function
REQ-010 SHALL grant combinationally in the same cycle as the request; at most one of core_gnt_o and prog_gnt_o is high per cycle.
REQ-011 SHALL hold a 2-state priority FSM, PRIO_PROG (reset) and PRIO_CORE, plus a wait counter wait_q of 4 bits.
REQ-012 In PRIO_PROG, SHALL grant prog when prog_req_i=1; otherwise it SHALL grant core when core_req_i=1.
REQ-013 In PRIO_CORE, SHALL grant core when core_req_i=1; otherwise it SHALL grant prog when prog_req_i=1.
REQ-014 SHALL increment wait_q in each cycle with core_req_i=1 and core_gnt_o=0, and SHALL clear it on a core grant or when core_req_i=0.
REQ-015 SHALL move PRIO_PROG->PRIO_CORE when a core stall occurs with wait_q==MAX_WAIT-1.
REQ-016 SHALL move PRIO_CORE->PRIO_PROG after one cycle, whether or not the core was granted.
REQ-017 With prog granted, SHALL drive ram_en_o=1, ram_we_o=4'hF, ram_a_o=prog_addr_i and ram_di_o=prog_wdata_i.
REQ-018 With core granted, SHALL drive ram_en_o=1, ram_a_o=core_addr_i, ram_di_o=core_wdata_i, and ram_we_o[i]=core_we_i AND (OR of core_wmask_i[8i+7:8i]).
REQ-019 With no grant, SHALL drive ram_en_o=0, ram_we_o=0, ram_a_o=0 and ram_di_o=0.
REQ-020 SHALL register core_rvalid_o as 1 exactly in the cycle after a granted core read (core_we_i=0); a core write, a prog grant or no grant gives 0 next cycle.
REQ-021 SHALL pass core_rdata_o=ram_do_i unregistered; it is valid only when core_rvalid_o=1.
REQ-022 A core write with core_wmask_i=0 SHALL be granted, with ram_en_o=1, ram_we_o=0 and no rvalid.

Reset
REQ-023 On rst_ni=0, SHALL immediately set FSM=PRIO_PROG, wait_q=0, core_rvalid_o=0 and conflict_cnt_o=0.
REQ-024 A reset mid-read SHALL suppress the pending rvalid; grants stay combinational from the inputs during reset.

Configuration
REQ-025 With macro RAM_ARB_PERF_EN defined, conflict_cnt_o SHALL increment in each cycle with prog_req_i=1 and core_req_i=1, saturating at 16'hFFFF.
REQ-026 Without RAM_ARB_PERF_EN, conflict_cnt_o SHALL be constant 0, with no counter flops.

Verification
REQ-027 Core read to addr 8'h10 alone, with ram_do_i=32'hDEADBEEF next cycle -> core_gnt_o=1, ram_we_o=0, ram_a_o=8'h10; next cycle core_rvalid_o=1, core_rdata_o=32'hDEADBEEF.
REQ-028 Core write with wmask 32'h00FF00FF -> ram_we_o=4'b0101, core_rvalid_o=0 next cycle.
REQ-029 Both requesting continuously, MAX_WAIT=4 -> prog granted cycles 0-3, core granted cycle 4, prog granted cycle 5, pattern repeats every 5 cycles.
REQ-030 prog_req_i=1 with addr 8'hFF, data 32'h12345678 -> ram_we_o=4'hF, ram_a_o=8'hFF, ram_di_o=32'h12345678, prog_gnt_o=1.
REQ-031 rst_ni pulsed low between a granted core read and its rvalid cycle -> core_rvalid_o stays 0; FSM returns to PRIO_PROG.
REQ-032 With RAM_ARB_PERF_EN, 10 cycles of simultaneous requests -> conflict_cnt_o=10; counter preloaded to 16'hFFFF stays at 16'hFFFF; without the macro -> 0.

Source files
------------

// File: rtl/iccm_ram_arbiter.sv
// iccm_ram_arbiter
// ----------------
// Two-master arbiter in front of a single-port DFFRAM holding the ICCM.
// The program loader (write-only) normally has priority. The core wins
// after MAX_WAIT consecutive stalled cycles, but only for one cycle.
// Grants are combinational. Read data comes straight from the RAM one
// cycle after a granted core read.
//
// Optional feature (macro RAM_ARB_PERF_EN): a saturating 16-bit counter
// of cycles in which both masters request. When the macro is undefined
// the counter output is tied to zero.
//
// Valid/ready semantics: a master holds *_req_i and its payload stable
// until it sees *_gnt_o high. A transfer happens in a cycle where both
// req and gnt are high. core_rvalid_o is a one-cycle pulse with no
// back-pressure.
//
// Ports
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   core_*_i / core_*_o  : core request, grant, read response
//   prog_*_i / prog_gnt_o: program-loader write port and grant
//   ram_*_o / ram_do_i   : DFFRAM macro interface (ram_we_o = byte enables)
//   conflict_cnt_o       : count of cycles with both masters requesting
//   prio_state_o         : debug view of the priority FSM (0=PROG, 1=CORE)
module iccm_ram_arbiter #(
    parameter int AW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [31:0]   core_wdata_i,
    input  logic [31:0]   core_wmask_i,
    output logic          core_gnt_o,
    output logic [31:0]   core_rdata_o,
    output logic          core_rvalid_o,
    input  logic          prog_req_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [31:0]   prog_wdata_i,
    output logic          prog_gnt_o,
    output logic          ram_en_o,
    output logic [3:0]    ram_we_o,
    output logic [AW-1:0] ram_a_o,
    output logic [31:0]   ram_di_o,
    input  logic [31:0]   ram_do_i,
    output logic [15:0]   conflict_cnt_o,
    output logic          prio_state_o
);

    typedef enum logic {
        PRIO_PROG = 1'b0,
        PRIO_CORE = 1'b1
    } prio_e;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    prio_e      state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       rvalid_q, rvalid_d;
    logic       core_stall;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= PRIO_PROG;
            wait_q   <= 4'd0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state logic
    assign core_stall = core_req_i && !core_gnt_o;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PRIO_PROG: if (core_stall && (wait_q == WAIT_LAST)) state_d = PRIO_CORE;
            PRIO_CORE: state_d = PRIO_PROG;  // core priority lasts one cycle
            default:   state_d = PRIO_PROG;
        endcase
    end

    // Any cycle where the core does not stall restarts the starvation count
    assign wait_d   = core_stall ? (wait_q + 4'd1) : 4'd0;
    assign rvalid_d = core_gnt_o && !core_we_i;

    // Output logic: grants and RAM muxing
    always_comb begin
        core_gnt_o = 1'b0;
        prog_gnt_o = 1'b0;
        if (state_q == PRIO_CORE) begin
            if (core_req_i)      core_gnt_o = 1'b1;
            else if (prog_req_i) prog_gnt_o = 1'b1;
        end else begin
            if (prog_req_i)      prog_gnt_o = 1'b1;
            else if (core_req_i) core_gnt_o = 1'b1;
        end

        ram_en_o = 1'b0;
        ram_we_o = 4'h0;
        ram_a_o  = '0;
        ram_di_o = 32'h0;
        if (prog_gnt_o) begin
            ram_en_o = 1'b1;
            ram_we_o = 4'hF;
            ram_a_o  = prog_addr_i;
            ram_di_o = prog_wdata_i;
        end else if (core_gnt_o) begin
            ram_en_o = 1'b1;
            ram_a_o  = core_addr_i;
            ram_di_o = core_wdata_i;
            // A byte is written if any bit of its mask lane is set
            for (int i = 0; i < 4; i++) begin
                ram_we_o[i] = core_we_i && (|core_wmask_i[8*i +: 8]);
            end
        end
    end

    assign core_rvalid_o = rvalid_q;
    assign core_rdata_o  = ram_do_i;
    assign prio_state_o  = state_q;

`ifdef RAM_ARB_PERF_EN
    logic [15:0] conflict_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_q <= 16'h0;
        end else if (prog_req_i && core_req_i && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_cnt_o = 16'h0;
`endif

endmodule
